// File: rtl/pause_req_gen.sv
// -----------------------------------------------------------------------------
// pause_req_gen
//
// Produces a frame-aligned pause request for the core's pause controller.
// Two sources ask for a pause: a debounced toggle button (user pause), and the
// platform sleep/save-state request. Pause entry and exit only happen on a
// rising edge of vblank, so the core never stalls mid-frame. If video has
// stopped and no edge arrives, a timeout forces the transition. A sleep request
// is acknowledged once the core has been paused for a settle period.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples before the debounced button
//                    changes (>=2)
//   VBL_TIMEOUT      cycles spent waiting for a vblank edge before the
//                    transition is forced (>=2)
//   ACK_SETTLE       cycles in PAUSED before sleep_ack may assert (>=1)
//
// Ports:
//   clk_sys      in   system clock
//   reset        in   asynchronous, active-high reset
//   btn_pause    in   raw pause button (asynchronous, synchronized here)
//   pause_en     in   user-pause feature enable
//   vblank       in   core vertical blank level
//   sleep_req    in   platform sleep/save-state pause request (level)
//   pause_req    out  pause request to the pause controller (registered)
//   sleep_ack    out  core paused and settled for sleep (registered)
//   user_paused  out  user toggle latch state, for OSD/status (registered)
// -----------------------------------------------------------------------------
module pause_req_gen #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int VBL_TIMEOUT     = 2000000,
  parameter int ACK_SETTLE      = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic btn_pause,
  input  logic pause_en,
  input  logic vblank,
  input  logic sleep_req,
  output logic pause_req,
  output logic sleep_ack,
  output logic user_paused
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int WW = $clog2(VBL_TIMEOUT) + 1;
  localparam int SW = $clog2(ACK_SETTLE) + 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] WT_LAST = WW'(VBL_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLED = SW'(ACK_SETTLE);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND_P = 2'd1,
    PAUSED = 2'd2,
    PEND_R = 2'd3
  } state_t;

  // Settle counter stops at ACK_SETTLE so it can sit in PAUSED indefinitely.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    sat_inc = (v == SETTLED) ? v : v + 1'b1;
  endfunction

  logic          btn_p0;
  logic          btn_p1;
  logic          db;
  logic          db_d;
  logic [DW-1:0] dcnt;
  logic          vblank_d;
  logic [WW-1:0] wcnt;
  logic [SW-1:0] scnt;
  state_t        state;

  logic vbl_edge;
  logic want;
  logic db_rise;
  logic timeout;

  assign vbl_edge = vblank & ~vblank_d;
  assign want     = user_paused | sleep_req;
  assign db_rise  = db & ~db_d;
  assign timeout  = (wcnt == WT_LAST);

  // Stage p0/p1: two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn_pause;
      btn_p1 <= btn_p0;
    end
  end

  // Debounce: the sample must differ for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      db   <= 1'b0;
      db_d <= 1'b0;
      dcnt <= '0;
    end else begin
      db_d <= db;
      if (btn_p1 == db) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        db   <= btn_p1;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // User toggle latch; disabling the feature clears it and masks presses
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      user_paused <= 1'b0;
    end else if (!pause_en) begin
      user_paused <= 1'b0;
    end else if (db_rise) begin
      user_paused <= ~user_paused;
    end
  end

  // vblank_d resets high so a vblank already high at release is not an edge
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vblank_d <= 1'b1;
    end else begin
      vblank_d <= vblank;
    end
  end

  // Pause FSM; pause_req follows the registered state
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wcnt      <= '0;
      scnt      <= '0;
      pause_req <= 1'b0;
      sleep_ack <= 1'b0;
    end else begin
      sleep_ack <= (state == PAUSED) && sleep_req && (scnt == SETTLED);
      case (state)
        RUN: begin
          pause_req <= 1'b0;
          if (want) begin
            state <= PEND_P;
            wcnt  <= '0;
          end
        end
        PEND_P: begin
          wcnt <= wcnt + 1'b1;
          // A dropped request wins over a coincident edge or timeout
          if (!want) begin
            state <= RUN;
          end else if (vbl_edge || timeout) begin
            state     <= PAUSED;
            scnt      <= '0;
            pause_req <= 1'b1;
          end
        end
        PAUSED: begin
          pause_req <= 1'b1;
          scnt      <= sat_inc(scnt);
          if (!want) begin
            state <= PEND_R;
            wcnt  <= '0;
          end
        end
        PEND_R: begin
          wcnt <= wcnt + 1'b1;
          // Re-request restarts the settle period before acknowledging again
          if (want) begin
            state <= PAUSED;
            scnt  <= '0;
          end else if (vbl_edge || timeout) begin
            state     <= RUN;
            pause_req <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          pause_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pause_req_gen.sv
// -----------------------------------------------------------------------------
// tb_pause_req_gen
//
// Directed testbench for pause_req_gen with DEBOUNCE_CYCLES=4, VBL_TIMEOUT=100,
// ACK_SETTLE=3. Inputs are driven 1 ns after the rising clock edge, and outputs
// are sampled at the same point, so each value seen at cycle t reflects edge t.
// -----------------------------------------------------------------------------
module tb_pause_req_gen;

  logic clk_sys = 1'b0;
  logic reset;
  logic btn_pause;
  logic pause_en;
  logic vblank;
  logic sleep_req;
  logic pause_req;
  logic sleep_ack;
  logic user_paused;

  int cyc    = 0;
  int base   = 0;
  int n_chk  = 0;
  int n_fail = 0;

  pause_req_gen #(
    .DEBOUNCE_CYCLES(4),
    .VBL_TIMEOUT    (100),
    .ACK_SETTLE     (3)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .btn_pause  (btn_pause),
    .pause_en   (pause_en),
    .vblank     (vblank),
    .sleep_req  (sleep_req),
    .pause_req  (pause_req),
    .sleep_ack  (sleep_ack),
    .user_paused(user_paused)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  // Advance to cycle t relative to the current scenario base
  task automatic to(input int t);
    while (cyc < base + t) tick();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (cycle %0d)", tag, obs, exp, cyc - base);
    end
  endtask

  initial begin
    reset     = 1'b1;
    btn_pause = 1'b0;
    pause_en  = 1'b1;
    vblank    = 1'b0;
    sleep_req = 1'b0;
    tick(); tick(); tick();
    chk("rst_pause_req", pause_req, 1'b0);
    chk("rst_sleep_ack", sleep_ack, 1'b0);
    chk("rst_user_paused", user_paused, 1'b0);
    reset = 1'b0;
    tick(); tick();

    // Debounce: short glitches are rejected, a held press toggles
    base = cyc;
    btn_pause = 1'b1;
    to(1);  btn_pause = 1'b0;
    to(10); chk("glitch1", user_paused, 1'b0);
    btn_pause = 1'b1;
    to(12); btn_pause = 1'b0;
    to(20); chk("glitch2", user_paused, 1'b0);
    btn_pause = 1'b1;
    to(23); btn_pause = 1'b0;
    to(30); chk("glitch3", user_paused, 1'b0);
    btn_pause = 1'b1;
    to(36); chk("press1_early", user_paused, 1'b0);
    to(37); chk("press1_toggle", user_paused, 1'b1);
    to(40); btn_pause = 1'b0;
    to(60); chk("press1_no_vbl", pause_req, 1'b0);
    btn_pause = 1'b1;
    to(66); chk("press2_early", user_paused, 1'b1);
    to(67); chk("press2_toggle", user_paused, 1'b0);
    to(70); btn_pause = 1'b0;
    to(80);

    // Frame alignment of entry and exit
    base = cyc;
    btn_pause = 1'b1;
    to(7);  chk("frame_up", user_paused, 1'b1);
    base = cyc;
    btn_pause = 1'b0;
    to(39); chk("frame_wait", pause_req, 1'b0);
    to(40); chk("frame_pre_edge", pause_req, 1'b0);
    vblank = 1'b1;
    to(41); chk("frame_enter", pause_req, 1'b1);
    to(50); vblank = 1'b0;
    to(240); btn_pause = 1'b1;
    to(247); chk("frame_untoggle", user_paused, 1'b0);
    to(250); btn_pause = 1'b0;
    to(300); chk("frame_hold", pause_req, 1'b1);
    vblank = 1'b1;
    to(301); chk("frame_exit", pause_req, 1'b0);
    to(302); vblank = 1'b0;
    to(310);

    // Timeout with video stopped, plus sleep acknowledge
    base = cyc;
    sleep_req = 1'b1;
    to(100); chk("tmo_pre", pause_req, 1'b0);
    to(101); chk("tmo_enter", pause_req, 1'b1);
    to(104); chk("ack_pre", sleep_ack, 1'b0);
    to(105); chk("ack_rise", sleep_ack, 1'b1);
    to(110); sleep_req = 1'b0;
    to(111); chk("ack_drop", sleep_ack, 1'b0);
    to(210); chk("tmo_rel_pre", pause_req, 1'b1);
    to(211); chk("tmo_release", pause_req, 1'b0);
    to(215);

    // Cancellation in PEND_P coincident with a vblank edge
    base = cyc;
    sleep_req = 1'b1;
    to(20); sleep_req = 1'b0; vblank = 1'b1;
    to(21); chk("cancel_edge", pause_req, 1'b0);
    to(22); vblank = 1'b0;
    to(130); chk("cancel_no_tmo", pause_req, 1'b0);

    // Re-request in PEND_R re-settles the acknowledge
    base = cyc;
    sleep_req = 1'b1;
    to(5);  vblank = 1'b1;
    to(6);  chk("rr_enter", pause_req, 1'b1);
    to(7);  vblank = 1'b0;
    to(10); chk("rr_ack", sleep_ack, 1'b1);
    to(20); sleep_req = 1'b0;
    to(21); chk("rr_ack_drop", sleep_ack, 1'b0);
    chk("rr_pend_r", pause_req, 1'b1);
    to(30); sleep_req = 1'b1;
    to(31); chk("rr_back", pause_req, 1'b1);
    to(34); chk("rr_settle_pre", sleep_ack, 1'b0);
    to(35); chk("rr_settle", sleep_ack, 1'b1);

    // Reset while paused and acknowledged
    to(40); btn_pause = 1'b1;
    to(47); chk("rs_up", user_paused, 1'b1);
    to(50); btn_pause = 1'b0;
    to(60);
    chk("rs_pre_pr", pause_req, 1'b1);
    chk("rs_pre_ack", sleep_ack, 1'b1);
    reset = 1'b1;
    #1;
    chk("rs_async_pr", pause_req, 1'b0);
    chk("rs_async_ack", sleep_ack, 1'b0);
    chk("rs_async_up", user_paused, 1'b0);
    to(62); vblank = 1'b1; reset = 1'b0;
    to(70); chk("rs_up_clear", user_paused, 1'b0);
    to(80); chk("rs_no_level_edge", pause_req, 1'b0);
    to(90); vblank = 1'b0;
    to(95); chk("rs_wait", pause_req, 1'b0);
    vblank = 1'b1;
    to(96); chk("rs_enter", pause_req, 1'b1);
    to(97); vblank = 1'b0;

    // Disabling the feature while user-paused
    base = cyc;
    sleep_req = 1'b0;
    to(5);  vblank = 1'b1;
    to(6);  chk("dis_run", pause_req, 1'b0);
    to(7);  vblank = 1'b0;
    to(10); btn_pause = 1'b1;
    to(17); chk("dis_up", user_paused, 1'b1);
    to(20); btn_pause = 1'b0;
    to(25); vblank = 1'b1;
    to(26); chk("dis_enter", pause_req, 1'b1);
    to(27); vblank = 1'b0;
    to(40); chk("dis_up_hold", user_paused, 1'b1);
    pause_en = 1'b0;
    to(41); chk("dis_up_clear", user_paused, 1'b0);
    to(60); chk("dis_hold", pause_req, 1'b1);
    vblank = 1'b1;
    to(61); chk("dis_exit", pause_req, 1'b0);
    to(62); vblank = 1'b0;
    to(70); btn_pause = 1'b1;
    to(80); chk("dis_ignore", user_paused, 1'b0);
    btn_pause = 1'b0;
    to(90);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pause_req_gen.md
# pause_req_gen

Generates the frame-aligned `pause_req` that feeds the core's pause controller, where it is OR-ed with the synchronized menu status.
- Inputs: a user pause button (debounced toggle) and the platform sleep/save-state request.
- Pause entry and exit are aligned to the rising edge of vblank, so the core never stalls mid-frame.
- A timeout forces the transition if video is stopped.
- Sleep requests receive `sleep_ack` once the pause has settled.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 50000: consecutive differing samples required before the debounced button changes (≥2).
- `VBL_TIMEOUT`, 2000000: cycles spent waiting for a vblank edge before the transition is forced (≥2).
- `ACK_SETTLE`, 16: cycles in PAUSED before `sleep_ack` may assert (≥1).

Ports:
- `clk_sys`  in  1  system clock; everything in this block is synchronous to it.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_pause`  in  1  raw pause button, asynchronous; passed through a 2-flop synchronizer inside the block.
- `pause_en`  in  1  user-pause feature enable (setting), synchronous.
- `vblank`  in  1  core vertical blank, synchronous level.
- `sleep_req`  in  1  platform sleep/save-state pause request, synchronous level.
- `pause_req`  out  1  pause request to the pause controller, registered.
- `sleep_ack`  out  1  core is paused and settled for sleep, registered.
- `user_paused`  out  1  user toggle latch state (for OSD/status), registered.

## Operation
- Reset values: all outputs 0; state RUN; synchronizer 0; debounced button 0; all counters 0; `vblank_d` = 1, so a `vblank` already high at reset release is not an edge.
- Debounce:
  - The counter clears whenever the synced sample equals the debounced value, and increments otherwise.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the sample still differs, the debounced value takes the sample and the counter clears.
- User latch:
  - A debounced rising edge with `pause_en`=1 toggles `user_paused`.
  - `pause_en`=0 clears `user_paused` on the next cycle, and edges are ignored.
- `vbl_edge` = `vblank` & ~`vblank_d`.
- `want` = `user_paused` | `sleep_req`.
- FSM, with a shared wait counter `wcnt` and a settle counter `scnt`:
  - RUN: `pause_req`=0. If `want`=1, go to PEND_P and clear `wcnt`.
  - PEND_P: `pause_req`=0, `wcnt` increments.
    - `want`=0 → RUN. Cancellation has priority over a same-cycle `vbl_edge` or timeout.
    - Else `vbl_edge`=1 or `wcnt`=`VBL_TIMEOUT-1` → PAUSED, with `scnt` cleared.
  - PAUSED: `pause_req`=1. `scnt` increments and saturates at `ACK_SETTLE`. If `want`=0, go to PEND_R and clear `wcnt`.
  - PEND_R: `pause_req`=1, `wcnt` increments.
    - `want`=1 → PAUSED, with `scnt` cleared (re-settle).
    - Else `vbl_edge` or `wcnt`=`VBL_TIMEOUT-1` → RUN.
- `sleep_ack` = 1 only in PAUSED with `sleep_req`=1 and `scnt`=`ACK_SETTLE`. It drops the cycle after `sleep_req` falls.
- Counter widths are `$clog2` of each parameter plus 1. Counters never wrap: `wcnt` is cleared on state entry, and `scnt` saturates.
- Reset asserted mid-operation drops every output to 0 asynchronously. After release the block starts in RUN, even if `want`=1; the pause is re-requested at the next vblank edge.

## Timing
- Button path:
  - 2 cycles of synchronizer.
  - `DEBOUNCE_CYCLES` cycles of stable differing sample, then the debounced value updates.
  - `user_paused` updates 1 cycle later.
- FSM transitions register on the clock edge that samples the condition. `pause_req` changes in the cycle after the `vbl_edge` cycle, i.e. latency 1 from the first high `vblank` sample.
- Timeout: with no vblank edge, `pause_req` changes `VBL_TIMEOUT` cycles after entering a PEND state.
- `sleep_ack` rises `ACK_SETTLE`+1 cycles after `pause_req` rises, when `sleep_req` is held.
- A `vblank` held high produces only one edge. Entering PEND while `vblank` is already high waits for the next frame.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `VBL_TIMEOUT`=100, `ACK_SETTLE`=3.

- **Debounce:** `btn_pause` with `pause_en`=1, glitches of 1–3 cycles → `user_paused` stays 0. Hold 10 cycles → `user_paused`=1 exactly 2+4+1 cycles after the press. Release and press again → `user_paused`=0.
- **Frame alignment:** `user_paused`=1 at cycle 0, `vblank` rises at cycle 40 → `pause_req`=1 at cycle 41, not earlier. Clear the toggle and raise `vblank` at cycle 300 → `pause_req`=0 at cycle 301.
- **Timeout:** `vblank` held 0, `sleep_req`=1 → `pause_req`=1 exactly 100 cycles after entering PEND_P. `sleep_ack`=1 4 cycles later. Drop `sleep_req` → `sleep_ack`=0 next cycle, and `pause_req`=0 100 cycles after that.
- **Cancellation:** in PEND_P, drop `sleep_req` in the same cycle as the `vblank` rise → `pause_req` stays 0 and the state returns to RUN. In PEND_R, re-raise `want` → return to PAUSED, and `sleep_ack` re-settles over 3 cycles.
- **Reset in PAUSED** with `sleep_ack`=1 → `pause_req`, `sleep_ack` and `user_paused` are 0 immediately. With `vblank` high at release, there is no pause until the next `vblank` rise.
- **Disable:** `pause_en` 1→0 while user-paused → `user_paused`=0 next cycle, and `pause_req` falls at the next vblank edge + 1.
